// File: rtl/cpu_wb_arbiter_pkg.sv
// Shared write-back definitions: datapath widths and requester encoding.
// Imported by cpu_wb_scoreboard and cpu_wb_arbiter.
`timescale 1ns/1ps
package cpu_defs;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NREG   = 32;

  typedef enum logic {
    REQ_EX  = 1'b0,
    REQ_LSU = 1'b1
  } req_e;

  function automatic req_e req_other(input req_e r);
    req_e o;
    case (r)
      REQ_EX:  o = REQ_LSU;
      REQ_LSU: o = REQ_EX;
      default: o = REQ_EX;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/cpu_wb_scoreboard.sv
// Pending-write scoreboard for long-latency destinations.
// Tracks busy registers and raises a stall when an id operand hits one.
`timescale 1ns/1ps
module cpu_wb_scoreboard
  import cpu_defs::*;
#(
  parameter int ADDR_W = cpu_defs::ADDR_W,
  parameter int NREG   = cpu_defs::NREG
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              set_en_i,
  input  logic [ADDR_W-1:0] set_addr_i,
  input  logic              clr_en_i,
  input  logic [ADDR_W-1:0] clr_addr_i,
  input  logic [ADDR_W-1:0] raddr1_i,
  input  logic [ADDR_W-1:0] raddr2_i,
  input  logic [ADDR_W-1:0] rd_i,
  output logic              stall_o
);

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;
  logic            hit1_s;
  logic            hit2_s;
  logic            hit_rd_s;

  // A write landing this cycle is served by the file's bypass, so it does not stall.
  function automatic logic sb_hit(input logic [NREG-1:0]   busy,
                                  input logic [ADDR_W-1:0] a,
                                  input logic              clr_en,
                                  input logic [ADDR_W-1:0] clr_addr);
    return (a != {ADDR_W{1'b0}}) && busy[a] && !(clr_en && (clr_addr == a));
  endfunction

  // Next busy vector: clear first so a same-index set overrides it.
  always_comb begin
    busy_d = busy_q;
    if (clr_en_i) begin
      busy_d[clr_addr_i] = 1'b0;
    end else begin
      busy_d = busy_q;
    end
    if (set_en_i && (set_addr_i != {ADDR_W{1'b0}})) begin
      busy_d[set_addr_i] = 1'b1;
    end else begin
      busy_d[0] = 1'b0;
    end
    busy_d[0] = 1'b0;
  end

  // Busy vector register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q <= {NREG{1'b0}};
    end else begin
      busy_q <= busy_d;
    end
  end

  // Hazard lookups on both sources and the candidate destination.
  always_comb begin
    hit1_s   = sb_hit(busy_q, raddr1_i, clr_en_i, clr_addr_i);
    hit2_s   = sb_hit(busy_q, raddr2_i, clr_en_i, clr_addr_i);
    hit_rd_s = sb_hit(busy_q, rd_i, clr_en_i, clr_addr_i);
    if (!rst_n) begin
      stall_o = 1'b0;
    end else begin
      stall_o = hit1_s | hit2_s | hit_rd_s;
    end
  end

endmodule

// File: rtl/cpu_wb_arbiter.sv
// Register-file write-port arbiter between ex and lsu, plus load scoreboard.
// Define PRIRV32_WB_RR_EN for round-robin arbitration; default is fixed lsu>ex.
`timescale 1ns/1ps
module cpu_wb_arbiter
  import cpu_defs::*;
#(
  parameter int DATA_W = cpu_defs::DATA_W,
  parameter int ADDR_W = cpu_defs::ADDR_W,
  parameter int NREG   = cpu_defs::NREG
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid_i,
  input  logic [ADDR_W-1:0] ex_waddr_i,
  input  logic [DATA_W-1:0] ex_wdata_i,
  output logic              ex_ready_o,
  input  logic              lsu_valid_i,
  input  logic [ADDR_W-1:0] lsu_waddr_i,
  input  logic [DATA_W-1:0] lsu_wdata_i,
  output logic              lsu_ready_o,
  input  logic              issue_i,
  input  logic [ADDR_W-1:0] issue_rd_i,
  input  logic [ADDR_W-1:0] raddr1_i,
  input  logic [ADDR_W-1:0] raddr2_i,
  output logic              stall_o,
  output logic              we_o,
  output logic [ADDR_W-1:0] waddr_o,
  output logic [DATA_W-1:0] wdata_o
);

  logic gnt_ex_s;
  logic gnt_lsu_s;
  logic both_s;

  assign both_s = ex_valid_i & lsu_valid_i;

`ifdef PRIRV32_WB_RR_EN
  req_e ptr_q;
  req_e ptr_d;

  // Preferred requester flips only when it wins a contested cycle.
  always_comb begin
    ptr_d = ptr_q;
    if (rst_n && both_s) begin
      ptr_d = req_other(ptr_q);
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q <= REQ_EX;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`endif

  // Grant selection: one winner per cycle, nothing while in reset.
  always_comb begin
    gnt_ex_s  = 1'b0;
    gnt_lsu_s = 1'b0;
    if (!rst_n) begin
      gnt_ex_s  = 1'b0;
      gnt_lsu_s = 1'b0;
    end else if (both_s) begin
`ifdef PRIRV32_WB_RR_EN
      if (ptr_q == REQ_LSU) begin
        gnt_lsu_s = 1'b1;
      end else begin
        gnt_ex_s = 1'b1;
      end
`else
      gnt_lsu_s = 1'b1;
`endif
    end else begin
      gnt_ex_s  = ex_valid_i;
      gnt_lsu_s = lsu_valid_i;
    end
  end

  // Write-port mux driven straight from the grants.
  always_comb begin
    ex_ready_o  = gnt_ex_s;
    lsu_ready_o = gnt_lsu_s;
    we_o        = gnt_ex_s | gnt_lsu_s;
    waddr_o     = {ADDR_W{1'b0}};
    wdata_o     = {DATA_W{1'b0}};
    if (gnt_lsu_s) begin
      waddr_o = lsu_waddr_i;
      wdata_o = lsu_wdata_i;
    end else if (gnt_ex_s) begin
      waddr_o = ex_waddr_i;
      wdata_o = ex_wdata_i;
    end else begin
      waddr_o = {ADDR_W{1'b0}};
      wdata_o = {DATA_W{1'b0}};
    end
  end

  cpu_wb_scoreboard #(
    .ADDR_W (ADDR_W),
    .NREG   (NREG)
  ) u_scoreboard (
    .clk        (clk),
    .rst_n      (rst_n),
    .set_en_i   (issue_i),
    .set_addr_i (issue_rd_i),
    .clr_en_i   (gnt_lsu_s),
    .clr_addr_i (lsu_waddr_i),
    .raddr1_i   (raddr1_i),
    .raddr2_i   (raddr2_i),
    .rd_i       (issue_rd_i),
    .stall_o    (stall_o)
  );

endmodule
